// File: rtl/core_types_pkg.sv
// core_types_pkg
// Shared core sizing constants and the writeback payload type used by the
// PRF writeback arbiter and its round-robin sub-arbiter.
//   PRF_WR_COUNT       : number of writeback requestors (ALU/LDU/MDU pipes)
//   PRF_BANK_COUNT     : number of PRF banks (power of 2)
//   LOG_PRF_BANK_COUNT : bank select width, taken from the low PR bits
//   LOG_PR_COUNT       : physical register index width
//   LOG_ROB_ENTRIES    : ROB index width
package core_types_pkg;

  localparam int PRF_WR_COUNT       = 4;
  localparam int PRF_BANK_COUNT     = 4;
  localparam int LOG_PRF_BANK_COUNT = 2;
  localparam int LOG_PR_COUNT       = 7;
  localparam int LOG_ROB_ENTRIES    = 7;

  localparam int LOG_PRF_WR_COUNT = (PRF_WR_COUNT > 1) ? $clog2(PRF_WR_COUNT) : 1;
  localparam int UPPER_PR_WIDTH   = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

  // Payload carried from a requestor buffer onto a bank's writeback bus.
  // The bank select bits are not stored here: they are implied by the bank.
  typedef struct packed {
    logic [31:0]                  data;
    logic [UPPER_PR_WIDTH-1:0]    upper_PR;
    logic [LOG_ROB_ENTRIES-1:0]   ROB_index;
  } prf_wb_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin picker. Grants the first asserted request
// at or after i_ptr, searching upward and wrapping REQ_COUNT-1 -> 0.
//   i_req       : request vector
//   i_ptr       : index with highest priority this cycle
//   o_grant     : one-hot grant (all zero when nothing requests)
//   o_grantIdx  : index of the granted request (0 when nothing requests)
//   o_anyGrant  : some request was granted
module rr_arbiter #(
  parameter  int REQ_COUNT = 4,
  localparam int IDX_W     = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
  input  logic [REQ_COUNT-1:0] i_req,
  input  logic [IDX_W-1:0]     i_ptr,
  output logic [REQ_COUNT-1:0] o_grant,
  output logic [IDX_W-1:0]     o_grantIdx,
  output logic                 o_anyGrant
);

  // Walk the requests starting at the pointer; the first hit wins and
  // suppresses every later position in the cyclic search.
  always_comb begin
    o_grant    = '0;
    o_grantIdx = '0;
    o_anyGrant = 1'b0;
    for (int k = 0; k < REQ_COUNT; k++) begin
      if (!o_anyGrant && i_req[(int'(i_ptr) + k) % REQ_COUNT]) begin
        o_grant[(int'(i_ptr) + k) % REQ_COUNT] = 1'b1;
        o_grantIdx = IDX_W'((int'(i_ptr) + k) % REQ_COUNT);
        o_anyGrant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prf_wb_arbiter.sv
// prf_wb_arbiter
// Per-bank writeback arbiter in front of the banked PRF write ports. Each
// requestor owns a one-entry holding buffer; each bank picks at most one
// buffered request per cycle with its own round-robin pointer, and the winner
// is registered onto that bank's writeback bus (PRF write + IQ/ROB broadcast).
//   CLK, RST                 : clock, synchronous active-high reset
//   WB_valid_by_wr           : request valid per requestor
//   WB_data_by_wr            : writeback data per requestor
//   WB_PR_by_wr              : destination PR (low bits select the bank)
//   WB_ROB_index_by_wr       : ROB index per requestor
//   WB_ready_by_wr           : requestor may present a new request this cycle
//   WB_bus_valid_by_bank     : registered bank write/broadcast valid
//   WB_bus_data_by_bank      : registered write data
//   WB_bus_upper_PR_by_bank  : registered PR bits above the bank select
//   WB_bus_ROB_index_by_bank : registered ROB index
module prf_wb_arbiter
  import core_types_pkg::*;
(
  input  logic                                             CLK,
  input  logic                                             RST,
  input  logic [PRF_WR_COUNT-1:0]                          WB_valid_by_wr,
  input  logic [PRF_WR_COUNT-1:0][31:0]                    WB_data_by_wr,
  input  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]        WB_PR_by_wr,
  input  logic [PRF_WR_COUNT-1:0][LOG_ROB_ENTRIES-1:0]     WB_ROB_index_by_wr,
  output logic [PRF_WR_COUNT-1:0]                          WB_ready_by_wr,
  output logic [PRF_BANK_COUNT-1:0]                        WB_bus_valid_by_bank,
  output logic [PRF_BANK_COUNT-1:0][31:0]                  WB_bus_data_by_bank,
  output logic [PRF_BANK_COUNT-1:0][UPPER_PR_WIDTH-1:0]    WB_bus_upper_PR_by_bank,
  output logic [PRF_BANK_COUNT-1:0][LOG_ROB_ENTRIES-1:0]   WB_bus_ROB_index_by_bank
);

  logic [PRF_WR_COUNT-1:0]             r_bufValid;
  prf_wb_entry_t                       r_bufEntry [PRF_WR_COUNT];
  logic [LOG_PRF_BANK_COUNT-1:0]       r_bufBank  [PRF_WR_COUNT];
  logic [LOG_PRF_WR_COUNT-1:0]         r_rrPtr    [PRF_BANK_COUNT];

  logic [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0]     w_reqByBank;
  logic [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0]     w_grantByBank;
  logic [PRF_BANK_COUNT-1:0][LOG_PRF_WR_COUNT-1:0] w_grantIdxByBank;
  logic [PRF_BANK_COUNT-1:0]                       w_anyGrantByBank;
  logic [PRF_WR_COUNT-1:0]                         w_grantByWr;
  logic [PRF_WR_COUNT-1:0]                         w_accept;

  // A buffer is a candidate only for the bank its PR maps to.
  always_comb begin
    w_reqByBank = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        w_reqByBank[b][i] = r_bufValid[i] && (r_bufBank[i] == LOG_PRF_BANK_COUNT'(b));
      end
    end
  end

  for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : g_bankArb
    rr_arbiter #(
      .REQ_COUNT (PRF_WR_COUNT)
    ) u_rrArbiter (
      .i_req      (w_reqByBank[b]),
      .i_ptr      (r_rrPtr[b]),
      .o_grant    (w_grantByBank[b]),
      .o_grantIdx (w_grantIdxByBank[b]),
      .o_anyGrant (w_anyGrantByBank[b])
    );
  end

  // Each requestor targets one bank, so OR-ing the bank grants gives a
  // per-requestor grant without any conflict.
  always_comb begin
    w_grantByWr = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      w_grantByWr = w_grantByWr | w_grantByBank[b];
    end
  end

  // A buffer being drained this cycle can refill in the same cycle, which is
  // what gives one request per cycle per uncontended requestor.
  assign WB_ready_by_wr = ~r_bufValid | w_grantByWr;
  assign w_accept       = WB_valid_by_wr & WB_ready_by_wr;

  // Holding buffers: load on accept, clear on a grant with no refill.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_bufValid <= '0;
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        r_bufEntry[i] <= '0;
        r_bufBank[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        if (w_accept[i]) begin
          r_bufValid[i] <= 1'b1;
          r_bufEntry[i] <= '{data:      WB_data_by_wr[i],
                             upper_PR:  WB_PR_by_wr[i][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT],
                             ROB_index: WB_ROB_index_by_wr[i]};
          r_bufBank[i]  <= WB_PR_by_wr[i][LOG_PRF_BANK_COUNT-1:0];
        end else if (w_grantByWr[i]) begin
          r_bufValid[i] <= 1'b0;
        end
      end
    end
  end

  // Bank bus and round-robin pointers. The pointer moves just past the
  // winner; payload fields hold when a bank is idle, only valid drops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      WB_bus_valid_by_bank     <= '0;
      WB_bus_data_by_bank      <= '0;
      WB_bus_upper_PR_by_bank  <= '0;
      WB_bus_ROB_index_by_bank <= '0;
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        r_rrPtr[b] <= '0;
      end
    end else begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        WB_bus_valid_by_bank[b] <= w_anyGrantByBank[b];
        if (w_anyGrantByBank[b]) begin
          WB_bus_data_by_bank[b]      <= r_bufEntry[w_grantIdxByBank[b]].data;
          WB_bus_upper_PR_by_bank[b]  <= r_bufEntry[w_grantIdxByBank[b]].upper_PR;
          WB_bus_ROB_index_by_bank[b] <= r_bufEntry[w_grantIdxByBank[b]].ROB_index;
          r_rrPtr[b] <= (w_grantIdxByBank[b] == LOG_PRF_WR_COUNT'(PRF_WR_COUNT - 1))
                        ? '0 : w_grantIdxByBank[b] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// tb_prf_wb_arbiter
// Directed scoreboard bench for prf_wb_arbiter. Requests are queued per
// requestor and driven with hold-until-accepted behaviour; the expected bus
// payload for each request is queued per bank, in the grant order worked out
// by hand for each scenario, and popped whenever that bank's bus goes valid.
module tb_prf_wb_arbiter;
  import core_types_pkg::*;

  localparam int W     = PRF_WR_COUNT;
  localparam int B     = PRF_BANK_COUNT;
  localparam int EXP_W = 32 + UPPER_PR_WIDTH + LOG_ROB_ENTRIES;

  logic                                   CLK = 1'b0;
  logic                                   RST = 1'b1;
  logic [W-1:0]                           WB_valid_by_wr;
  logic [W-1:0][31:0]                     WB_data_by_wr;
  logic [W-1:0][LOG_PR_COUNT-1:0]         WB_PR_by_wr;
  logic [W-1:0][LOG_ROB_ENTRIES-1:0]      WB_ROB_index_by_wr;
  logic [W-1:0]                           WB_ready_by_wr;
  logic [B-1:0]                           WB_bus_valid_by_bank;
  logic [B-1:0][31:0]                     WB_bus_data_by_bank;
  logic [B-1:0][UPPER_PR_WIDTH-1:0]       WB_bus_upper_PR_by_bank;
  logic [B-1:0][LOG_ROB_ENTRIES-1:0]      WB_bus_ROB_index_by_bank;

  typedef struct {
    logic [31:0]                 data;
    logic [LOG_PR_COUNT-1:0]     pr;
    logic [LOG_ROB_ENTRIES-1:0]  rob;
  } req_t;

  req_t             reqQ [W][$];
  logic [EXP_W-1:0] expQ [B][$];
  logic [EXP_W-1:0] expVal;
  logic [W-1:0]     acc;
  int compared   = 0;
  int mismatched = 0;

  prf_wb_arbiter dut (
    .CLK                      (CLK),
    .RST                      (RST),
    .WB_valid_by_wr           (WB_valid_by_wr),
    .WB_data_by_wr            (WB_data_by_wr),
    .WB_PR_by_wr              (WB_PR_by_wr),
    .WB_ROB_index_by_wr       (WB_ROB_index_by_wr),
    .WB_ready_by_wr           (WB_ready_by_wr),
    .WB_bus_valid_by_bank     (WB_bus_valid_by_bank),
    .WB_bus_data_by_bank      (WB_bus_data_by_bank),
    .WB_bus_upper_PR_by_bank  (WB_bus_upper_PR_by_bank),
    .WB_bus_ROB_index_by_bank (WB_bus_ROB_index_by_bank)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Queue a request on requestor wr; when expectOut is set, also queue the
  // bus payload it should produce on its bank.
  task automatic applyStimulus(input int wr, input logic [LOG_PR_COUNT-1:0] pr,
                               input logic [31:0] data, input logic [LOG_ROB_ENTRIES-1:0] rob,
                               input bit expectOut);
    req_t r;
    r.data = data;
    r.pr   = pr;
    r.rob  = rob;
    reqQ[wr].push_back(r);
    if (expectOut)
      expQ[int'(pr[LOG_PRF_BANK_COUNT-1:0])].push_back({data, pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT], rob});
  endtask

  task automatic waitValid(input logic [W-1:0] mask, input string tag);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (((WB_valid_by_wr & mask) != mask) && n < 50);
    if ((WB_valid_by_wr & mask) != mask)
      checkOutput(tag, 64'(WB_valid_by_wr & mask), 64'(mask));
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    int pending;
    do begin
      @(negedge CLK);
      n++;
      pending = 0;
      for (int i = 0; i < W; i++) pending += reqQ[i].size();
      for (int b = 0; b < B; b++) pending += expQ[b].size();
    end while (pending != 0 && n < 100);
    checkOutput(tag, 64'(pending), 64'd0);
  endtask

  task automatic pulseReset(input int cycles);
    @(posedge CLK);
    #1 RST = 1'b1;
    repeat (cycles) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  // Driver: a request presented in a cycle where ready was high (and reset
  // low) was taken at the following edge, so the next one is presented.
  initial begin
    WB_valid_by_wr     = '0;
    WB_data_by_wr      = '0;
    WB_PR_by_wr        = '0;
    WB_ROB_index_by_wr = '0;
    forever begin
      @(negedge CLK);
      acc = WB_valid_by_wr & WB_ready_by_wr & {W{~RST}};
      @(posedge CLK);
      #1;
      for (int i = 0; i < W; i++) begin
        if (acc[i] && reqQ[i].size() > 0) reqQ[i].delete(0);
        if (reqQ[i].size() > 0) begin
          WB_valid_by_wr[i]     = 1'b1;
          WB_data_by_wr[i]      = reqQ[i][0].data;
          WB_PR_by_wr[i]        = reqQ[i][0].pr;
          WB_ROB_index_by_wr[i] = reqQ[i][0].rob;
        end else begin
          WB_valid_by_wr[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: every valid bank beat must match the oldest expected payload.
  always @(negedge CLK) begin
    for (int b = 0; b < B; b++) begin
      if (WB_bus_valid_by_bank[b] === 1'b1) begin
        if (expQ[b].size() == 0) begin
          checkOutput($sformatf("unexpected_bank%0d", b), 64'(WB_bus_valid_by_bank[b]), 64'd0);
        end else begin
          expVal = expQ[b].pop_front();
          checkOutput($sformatf("bus_bank%0d", b),
                      64'({WB_bus_data_by_bank[b], WB_bus_upper_PR_by_bank[b], WB_bus_ROB_index_by_bank[b]}),
                      64'(expVal));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int drop;
    int run;
    int maxRun;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_bus_valid", 64'(WB_bus_valid_by_bank), 64'd0);
    checkOutput("rst_ready", 64'(WB_ready_by_wr), 64'hF);
    checkOutput("rst_bus_data0", 64'(WB_bus_data_by_bank[0]), 64'd0);
    @(posedge CLK);
    #1 RST = 1'b0;

    // Single request: PR 0x05 -> bank 1, upper 1, two cycles after accept
    applyStimulus(0, 7'h05, 32'hDEADBEEF, 7'd3, 1'b1);
    waitValid(4'b0001, "t1_wait");
    @(negedge CLK);
    checkOutput("t1_bus_after1", 64'(WB_bus_valid_by_bank), 64'd0);
    @(negedge CLK);
    checkOutput("t1_bus_after2", 64'(WB_bus_valid_by_bank), 64'b0010);
    waitDrain("t1_drain");

    // Parallel banks: all four land in the same cycle
    for (int i = 0; i < W; i++)
      applyStimulus(i, 7'(i), 32'hA5A5_0000 + 32'(i), 7'(10 + i), 1'b1);
    waitValid(4'hF, "t2_wait");
    @(negedge CLK);
    checkOutput("t2_ready_after1", 64'(WB_ready_by_wr), 64'hF);
    checkOutput("t2_bus_after1", 64'(WB_bus_valid_by_bank), 64'd0);
    @(negedge CLK);
    checkOutput("t2_bus_after2", 64'(WB_bus_valid_by_bank), 64'hF);
    checkOutput("t2_ready_after2", 64'(WB_ready_by_wr), 64'hF);
    waitDrain("t2_drain");

    // Contention on bank 2 from fresh pointers: order 0,1,2,3
    pulseReset(1);
    applyStimulus(0, 7'h02, 32'h2000_0000, 7'd20, 1'b1);
    applyStimulus(1, 7'h06, 32'h2000_0001, 7'd21, 1'b1);
    applyStimulus(2, 7'h0A, 32'h2000_0002, 7'd22, 1'b1);
    applyStimulus(3, 7'h0E, 32'h2000_0003, 7'd23, 1'b1);
    waitValid(4'hF, "t3_wait");
    @(negedge CLK);
    checkOutput("t3_ready_c1", 64'(WB_ready_by_wr), 64'b0001);
    @(negedge CLK);
    checkOutput("t3_ready_c2", 64'(WB_ready_by_wr), 64'b0011);
    checkOutput("t3_bus_c2", 64'(WB_bus_valid_by_bank), 64'b0100);
    waitDrain("t3_drain");
    // Pointer back at 0: requestor 0 beats requestor 3
    applyStimulus(0, 7'h12, 32'h2100_0000, 7'd24, 1'b1);
    applyStimulus(3, 7'h16, 32'h2100_0003, 7'd25, 1'b1);
    waitDrain("t3_ptr_drain");

    // Wrap-around: grant 2 on bank 1 moves its pointer to 3; then 3 before 0
    applyStimulus(2, 7'h01, 32'h3000_0002, 7'd30, 1'b1);
    waitDrain("t4_prime_drain");
    applyStimulus(3, 7'h05, 32'h3000_0003, 7'd31, 1'b1);
    applyStimulus(0, 7'h09, 32'h3000_0000, 7'd32, 1'b1);
    waitValid(4'b1001, "t4_wait");
    waitDrain("t4_drain");

    // Back-to-back stream from requestor 1 to bank 0
    applyStimulus(1, 7'h04, 32'h4000_0000, 7'd40, 1'b1);
    applyStimulus(1, 7'h08, 32'h4000_0001, 7'd41, 1'b1);
    applyStimulus(1, 7'h0C, 32'h4000_0002, 7'd42, 1'b1);
    drop = 0;
    run = 0;
    maxRun = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (WB_ready_by_wr[1] !== 1'b1) drop++;
      if (WB_bus_valid_by_bank[0] === 1'b1) run++;
      else run = 0;
      if (run > maxRun) maxRun = run;
    end
    checkOutput("t5_ready_drops", 64'(drop), 64'd0);
    checkOutput("t5_valid_run", 64'(maxRun), 64'd3);
    waitDrain("t5_drain");

    // Reset with three requests buffered for bank 0; none may reach the bus
    applyStimulus(0, 7'h10, 32'h5000_0000, 7'd50, 1'b0);
    applyStimulus(1, 7'h20, 32'h5000_0001, 7'd51, 1'b0);
    applyStimulus(2, 7'h30, 32'h5000_0002, 7'd52, 1'b0);
    waitValid(4'b0111, "t6_wait");
    @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    checkOutput("t6_bus_after_rst", 64'(WB_bus_valid_by_bank), 64'd0);
    checkOutput("t6_ready_after_rst", 64'(WB_ready_by_wr), 64'hF);
    // Bank 0 pointer was left at 2 before reset; after reset 0 wins over 3
    applyStimulus(0, 7'h44, 32'h6000_0000, 7'd60, 1'b1);
    applyStimulus(3, 7'h48, 32'h6000_0003, 7'd61, 1'b1);
    waitDrain("t6_drain");
    repeat (4) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/prf_wb_arbiter.md
Name: prf_wb_arbiter

Overview:
- Per-bank writeback arbiter that sits in front of the banked PRF write ports.
- Accepts writeback requests from PRF_WR_COUNT write requestors, such as ALU, LDU and MDU pipes, and buffers one request per requestor.
- Each cycle, grants at most one buffered request per bank using a per-bank round-robin.
- Drives the registered per-bank writeback bus that writes the PRF and broadcasts to the IQs and ROB. Requestors are backpressured with a ready signal.

Parameters:
- PRF_WR_COUNT, 4: number of write requestors.
- PRF_BANK_COUNT, 4: number of PRF banks; power of 2.
- LOG_PRF_BANK_COUNT, 2: log2(PRF_BANK_COUNT).
- LOG_PR_COUNT, 7: physical register index width.
- LOG_ROB_ENTRIES, 7: ROB index width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  reset.
- WB_valid_by_wr  in  [PRF_WR_COUNT]  request valid per requestor.
- WB_data_by_wr  in  [PRF_WR_COUNT][32]  writeback data.
- WB_PR_by_wr  in  [PRF_WR_COUNT][LOG_PR_COUNT]  destination PR.
- WB_ROB_index_by_wr  in  [PRF_WR_COUNT][LOG_ROB_ENTRIES]  ROB index.
- WB_ready_by_wr  out  [PRF_WR_COUNT]  requestor may present a new request this cycle.
- WB_bus_valid_by_bank  out  [PRF_BANK_COUNT]  bank write/broadcast valid.
- WB_bus_data_by_bank  out  [PRF_BANK_COUNT][32]  write data.
- WB_bus_upper_PR_by_bank  out  [PRF_BANK_COUNT][LOG_PR_COUNT-LOG_PRF_BANK_COUNT]  PR bits above the bank select.
- WB_bus_ROB_index_by_bank  out  [PRF_BANK_COUNT][LOG_ROB_ENTRIES]  ROB index.

Interface (already decided):
- One clock, CLK.
- Reset RST is synchronous and active-high.

Behaviour:
- Bank select:
  - bank = PR[LOG_PRF_BANK_COUNT-1:0].
  - upper_PR = PR[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT].
- State per requestor: a one-entry holding buffer with fields valid, data, bank, upper_PR and ROB index.
- State per bank: a round-robin pointer of width log2(PRF_WR_COUNT).
- Accept: on a cycle where WB_valid_by_wr[i] && WB_ready_by_wr[i], buffer i loads the request at the posedge.
- Ready (combinational): WB_ready_by_wr[i] = ~buf_valid[i] | grant[i].
  - A full buffer that is granted this cycle accepts a new request in the same cycle, giving back-to-back throughput of 1 per cycle per requestor when uncontended.
- Request valid while ready is low: ignored and not buffered. The requestor must hold the request.
- Arbitration (combinational, per bank b):
  - Candidates are the buffers with valid and bank == b.
  - Grant the first candidate at or after rr_ptr[b], searching cyclically upward and wrapping PRF_WR_COUNT-1 -> 0.
  - At most one grant per bank. A requestor targets exactly one bank, so at most one grant per requestor.
- Pointer update:
  - If bank b grants requestor g, rr_ptr[b] <= (g+1) mod PRF_WR_COUNT.
  - If bank b grants nothing, rr_ptr[b] holds.
- Buffer update:
  - Granted and no new accept: valid <= 0.
  - Granted and new accept: reload with the new request.
  - Not granted: hold.
- Bus (registered):
  - WB_bus_valid_by_bank[b] <= any grant on b.
  - data, upper_PR and ROB index are loaded from the granted buffer.
  - When no grant, data fields hold their previous value; only valid is meaningful.
- Latency:
  - A request accepted in cycle N is buffered in cycle N+1.
  - If granted in N+1, it appears on the bus in cycle N+2.
  - Minimum latency is 2 cycles.
- Fairness: with k requestors contending for one bank, each is granted within k cycles. No starvation.
- Simultaneous events:
  - Different banks grant independently in the same cycle.
  - Up to PRF_BANK_COUNT writes complete per cycle.
- Reset (RST high at posedge), which also applies mid-operation and discards buffered requests:
  - All buf_valid <= 0.
  - rr_ptr <= 0.
  - WB_bus_valid_by_bank <= 0.
  - Bus data, upper_PR and ROB index <= 0.
- Outputs during and after reset:
  - WB_ready_by_wr reads all 1s because the buffers are empty.
  - Requests presented while RST is high are not accepted.

Decomposition:
- core_types_pkg holds PRF_WR_COUNT, PRF_BANK_COUNT, LOG_PRF_BANK_COUNT, LOG_PR_COUNT and LOG_ROB_ENTRIES.
- Add to the same package a typedef struct prf_wb_entry_t {data, upper_PR, ROB_index}.
- Sub-module rr_arbiter:
  - Parameters: REQ_COUNT.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational; instantiated PRF_BANK_COUNT times. The pointer registers stay in prf_wb_arbiter.

Test Plan:
- Single request: reset, then requestor 0 sends PR=0x05, data=0xDEADBEEF, ROB=3 in cycle 1 -> two cycles after the accept:
  - bank 1 bus valid.
  - upper_PR=0x01, data=0xDEADBEEF, ROB=3.
  - All other banks invalid.
- Parallel banks: requestors 0-3 target PRs 0x00, 0x01, 0x02, 0x03 in the same cycle -> all 4 banks valid in the same later cycle, with upper_PR=0 and the matching data. Ready stays 1 throughout.
- Contention on one bank: requestors 0-3 all target bank 2 (PRs 0x02, 0x06, 0x0A, 0x0E) and hold valid ->
  - Grant order is 0, 1, 2, 3 over 4 consecutive cycles; bank 2 bus upper_PR sequence is 0, 1, 2, 3.
  - Ready drops for the waiting requestors.
  - rr_ptr[2] ends at 0.
- Wrap-around fairness: rr_ptr[1]=3 (reached by a prior grant to requestor 2), then requestors 0 and 3 both request bank 1 -> requestor 3 is granted first, then requestor 0.
- Back-to-back throughput: requestor 1 streams PRs 0x04, 0x08, 0x0C, all bank 0, uncontested -> bank 0 is valid for 3 consecutive cycles and WB_ready_by_wr[1] stays 1.
- Reset mid-operation: with 3 buffered requests contending for bank 0, assert RST for 1 cycle ->
  - Next cycle: all bus valids are 0 and all ready are 1.
  - The discarded requests never appear on the bus.
  - A new request after reset is granted with rr_ptr=0 ordering.
